// File: rtl/uart_attack_rx.sv
// 8N1 UART receiver that pairs two bytes (low, then high) into the 16-bit attack vector B_word.
// The last complete word is held stable. A bad stop bit or an inter-byte timeout discards the half-built frame.
module uart_attack_rx #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        rx,
  output logic [15:0] B_word,
  output logic        word_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int DIV      = CLK_HZ / BAUD;
  localparam int TW       = $clog2(DIV);
  localparam int TO_LIMIT = TIMEOUT_BITS * DIV;
  localparam int TOW      = $clog2(TO_LIMIT + 1);

  localparam logic [TW-1:0]  HALF_LOAD = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0]  FULL_LOAD = TW'(DIV - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(TO_LIMIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [1:0]     sync_q;
  logic [2:0]     state_q,    state_d;
  logic [TW-1:0]  timer_q,    timer_d;
  logic [2:0]     bit_cnt_q,  bit_cnt_d;
  logic [7:0]     shift_q,    shift_d;
  logic [7:0]     low_q,      low_d;
  logic           have_low_q, have_low_d;
  logic [TOW-1:0] to_cnt_q,   to_cnt_d;
  logic [15:0]    word_q,     word_d;
  logic           valid_q,    valid_d;
  logic           err_q,      err_d;

  logic rx_s;
  logic timer_done;

  assign rx_s       = sync_q[1];
  assign timer_done = (timer_q == '0);

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    low_d      = low_q;
    have_low_d = have_low_q;
    to_cnt_d   = to_cnt_q;
    word_d     = word_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          timer_d  = HALF_LOAD;
          to_cnt_d = '0;
          state_d  = S_START;
        end else if (have_low_q) begin
          if (to_cnt_q == TO_LAST) begin
            have_low_d = 1'b0;
            err_d      = 1'b1;
            to_cnt_d   = '0;
          end else begin
            to_cnt_d = to_cnt_q + TOW'(1);
          end
        end
      end

      S_START: begin
        if (!timer_done) begin
          timer_d = timer_q - TW'(1);
        end else if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          timer_d   = FULL_LOAD;
          bit_cnt_d = 3'd0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (!timer_done) begin
          timer_d = timer_q - TW'(1);
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          timer_d = FULL_LOAD;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end

      S_STOP: begin
        if (!timer_done) begin
          timer_d = timer_q - TW'(1);
        end else if (!rx_s) begin
          err_d      = 1'b1;
          have_low_d = 1'b0;
          state_d    = S_BREAK;
        end else if (have_low_q) begin
          word_d     = {shift_q, low_q};
          valid_d    = 1'b1;
          have_low_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          low_d      = shift_q;
          have_low_d = 1'b1;
          to_cnt_d   = '0;
          state_d    = S_IDLE;
        end
      end

      // A line held low after a bad stop must return high before a new start is accepted.
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (clr) begin
      sync_q     <= 2'b11;
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      low_q      <= 8'h00;
      have_low_q <= 1'b0;
      to_cnt_q   <= '0;
      word_q     <= 16'h0000;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      low_q      <= low_d;
      have_low_q <= have_low_d;
      to_cnt_q   <= to_cnt_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign B_word     = word_q;
  assign word_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != S_IDLE) || have_low_q;

endmodule
